// File: rtl/lsb_queue.sv
// In-order load/store buffer: holds memory ops in program order, snoops result
// broadcasts for missing operands and issues the head entry to the LS ALU.
module lsb_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned OP_W   = 6,
    parameter int unsigned IMM_W  = 32,
    parameter int unsigned NUM_WB = 2,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     flush,
    output logic                     LSB_is_full,
    output logic [IDX_W:0]           LSB_count,
    input  logic                     ID_input_valid,
    input  logic                     ID_is_store,
    input  logic [OP_W-1:0]          ID_OP_ID,
    input  logic [DATA_W-1:0]        ID_inst_pc,
    input  logic [IMM_W-1:0]         ID_imm,
    input  logic [ROB_W-1:0]         ROB_new_ID,
    input  logic                     RF_rs1_valid,
    input  logic                     RF_rs2_valid,
    input  logic [DATA_W-1:0]        RF_reg_rs1,
    input  logic [DATA_W-1:0]        RF_reg_rs2,
    input  logic [ROB_W-1:0]         RF_rs1_ROB_id,
    input  logic [ROB_W-1:0]         RF_rs2_ROB_id,
    input  logic [NUM_WB-1:0]        WB_valid,
    input  logic [NUM_WB*ROB_W-1:0]  WB_ROB_id,
    input  logic [NUM_WB*DATA_W-1:0] WB_value,
    input  logic                     ROB_commit_valid,
    input  logic [ROB_W-1:0]         ROB_commit_id,
    input  logic                     ALU_ready,
    output logic                     ALU_output_valid,
    output logic [OP_W-1:0]          ALU_OP_ID,
    output logic [DATA_W-1:0]        ALU_inst_pc,
    output logic [DATA_W-1:0]        ALU_reg_rs1,
    output logic [DATA_W-1:0]        ALU_reg_rs2,
    output logic [IMM_W-1:0]         ALU_imm,
    output logic [ROB_W-1:0]         ALU_ROB_id
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic              is_store;
        logic              committed;
        logic              rs1_rdy;
        logic              rs2_rdy;
        logic [ROB_W-1:0]  rs1_tag;
        logic [ROB_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs1_val;
        logic [DATA_W-1:0] rs2_val;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] pc;
        logic [IMM_W-1:0]  imm;
        logic [ROB_W-1:0]  rob;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            head_ent;
    entry_t            new_ent;
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  keep_cnt;
    logic              issue;
    logic              enq;
    logic              do_commit;

    logic [ROB_W-1:0]  wb_tag [NUM_WB];
    logic [DATA_W-1:0] wb_val [NUM_WB];

    // Unpack the broadcast channels.
    always_comb begin
        for (int k = 0; k < int'(NUM_WB); k++) begin
            wb_tag[k] = WB_ROB_id[k*ROB_W +: ROB_W];
            wb_val[k] = WB_value[k*DATA_W +: DATA_W];
        end
    end

    // Tag match across all channels; the lowest-numbered matching channel wins.
    function automatic logic [DATA_W:0] wb_lookup(input logic [ROB_W-1:0] tag);
        logic              hit;
        logic [DATA_W-1:0] val;
        hit = 1'b0;
        val = '0;
        for (int k = 0; k < int'(NUM_WB); k++) begin
            if (!hit && WB_valid[k] && (wb_tag[k] == tag)) begin
                hit = 1'b1;
                val = wb_val[k];
            end
        end
        return {hit, val};
    endfunction

    assign head_ent    = ent_q[head_q];
    assign LSB_is_full = (count_q == CNT_W'(DEPTH));
    assign LSB_count   = count_q;

    assign issue     = rdy && (count_q != '0) && head_ent.rs1_rdy && head_ent.rs2_rdy
                       && ALU_ready && (!head_ent.is_store || head_ent.committed);
    assign enq       = rdy && ID_input_valid && !LSB_is_full && !flush;
    assign do_commit = rdy && ROB_commit_valid && !flush;

    // Incoming entry, with same-cycle broadcast capture for missing operands.
    always_comb begin
        logic [DATA_W:0] m1;
        logic [DATA_W:0] m2;
        m1 = wb_lookup(RF_rs1_ROB_id);
        m2 = wb_lookup(RF_rs2_ROB_id);
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.is_store  = ID_is_store;
        new_ent.op        = ID_OP_ID;
        new_ent.pc        = ID_inst_pc;
        new_ent.imm       = ID_imm;
        new_ent.rob       = ROB_new_ID;
        new_ent.rs1_tag   = RF_rs1_ROB_id;
        new_ent.rs2_tag   = RF_rs2_ROB_id;
        if (RF_rs1_valid) begin
            new_ent.rs1_rdy = 1'b1;
            new_ent.rs1_val = RF_reg_rs1;
        end else if (m1[DATA_W]) begin
            new_ent.rs1_rdy = 1'b1;
            new_ent.rs1_val = m1[DATA_W-1:0];
        end
        if (RF_rs2_valid) begin
            new_ent.rs2_rdy = 1'b1;
            new_ent.rs2_val = RF_reg_rs2;
        end else if (m2[DATA_W]) begin
            new_ent.rs2_rdy = 1'b1;
            new_ent.rs2_val = m2[DATA_W-1:0];
        end
    end

    // Committed stores survive a flush; they sit contiguously from head.
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_q[i].valid && ent_q[i].committed) begin
                keep_cnt = keep_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state for entries and pointers.
    always_comb begin
        logic [DATA_W:0] m1;
        logic [DATA_W:0] m2;
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        m1      = '0;
        m2      = '0;
        if (rdy) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_q[i].valid) begin
                    m1 = wb_lookup(ent_q[i].rs1_tag);
                    m2 = wb_lookup(ent_q[i].rs2_tag);
                    if (!ent_q[i].rs1_rdy && m1[DATA_W]) begin
                        ent_d[i].rs1_rdy = 1'b1;
                        ent_d[i].rs1_val = m1[DATA_W-1:0];
                    end
                    if (!ent_q[i].rs2_rdy && m2[DATA_W]) begin
                        ent_d[i].rs2_rdy = 1'b1;
                        ent_d[i].rs2_val = m2[DATA_W-1:0];
                    end
                    if (do_commit && ent_q[i].is_store && (ent_q[i].rob == ROB_commit_id)) begin
                        ent_d[i].committed = 1'b1;
                    end
                end
            end
            if (issue) begin
                ent_d[head_q].valid     = 1'b0;
                ent_d[head_q].committed = 1'b0;
            end
            head_d = head_q + IDX_W'(issue);
            if (flush) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (!ent_q[i].committed) begin
                        ent_d[i].valid = 1'b0;
                    end
                end
                count_d = keep_cnt - CNT_W'(issue && head_ent.committed);
                tail_d  = head_d + count_d[IDX_W-1:0];
            end else begin
                if (enq) begin
                    ent_d[tail_q] = new_ent;
                end
                tail_d  = tail_q + IDX_W'(enq);
                count_d = count_q + CNT_W'(enq) - CNT_W'(issue);
            end
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= ent_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Issue registers toward the ALU.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALU_output_valid <= 1'b0;
            ALU_OP_ID        <= '0;
            ALU_inst_pc      <= '0;
            ALU_reg_rs1      <= '0;
            ALU_reg_rs2      <= '0;
            ALU_imm          <= '0;
            ALU_ROB_id       <= '0;
        end else begin
            ALU_output_valid <= issue;
            if (issue) begin
                ALU_OP_ID   <= head_ent.op;
                ALU_inst_pc <= head_ent.pc;
                ALU_reg_rs1 <= head_ent.rs1_val;
                ALU_reg_rs2 <= head_ent.rs2_val;
                ALU_imm     <= head_ent.imm;
                ALU_ROB_id  <= head_ent.rob;
            end
        end
    end

endmodule
